mult_ctrl: RTL and testbench

Control unit for the 8x8 shift-add multiplier datapath. It accepts a start/acknowledge handshake from the system side. It sequences the datapath's clear, load and enable strobes, and counts the iterations. It stops after a fixed number of steps, or early when the datapath reports the multiplier register is zero. It sits beside the datapath and drives that datapath's `clr`, `ld` and `en` inputs.

---
 rtl/mult_ctrl.sv | 90 +++++++++
 tb/tb_mult_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencer for the 8x8 shift-add multiplier: start/ack handshake, one-cycle
// clear and load strobes, then a counted run of step enables with optional early exit.
module mult_ctrl #(
  parameter int ITER       = 8,
  parameter int CW         = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic          ack,
  input  logic          b_zero,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          dp_clr,
  output logic          dp_ld,
  output logic          dp_en,
  output logic [CW-1:0] steps
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] steps_reg, steps_next;
  logic          last_step;
  logic          early_stop;

  // The exit test uses the pre-increment count, so the exiting edge still counts.
  assign last_step  = (steps_reg == CW'(ITER - 1));
  assign early_stop = (EARLY_EXIT != 0) && b_zero;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      steps_reg <= '0;
    end else begin
      state_reg <= state_next;
      steps_reg <= steps_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    steps_next = steps_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    dp_clr     = 1'b0;
    dp_ld      = 1'b0;
    dp_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        busy       = 1'b1;
        dp_clr     = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        dp_ld      = 1'b1;
        steps_next = '0;
        state_next = RUN;
      end
      RUN: begin
        busy       = 1'b1;
        dp_en      = 1'b1;
        steps_next = steps_reg + CW'(1);
        if (last_step || early_stop) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign steps = steps_reg;

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: expected run lengths are queued at start and
// compared when done is observed; a second instance covers EARLY_EXIT=0.
module tb_mult_ctrl;

  localparam int ITER = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b1;
  logic          start = 1'b0, ack = 1'b0, b_zero = 1'b0;
  logic          ready, busy, done, dp_clr, dp_ld, dp_en;
  logic [CW-1:0] steps;

  logic          start2 = 1'b0, ack2 = 1'b0, b_zero2 = 1'b1;
  logic          ready2, busy2, done2, dp_clr2, dp_ld2, dp_en2;
  logic [CW-1:0] steps2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int steps;
    int done_at;
  } exp_t;
  exp_t exp_q[$];

  mult_ctrl #(.ITER(ITER), .CW(CW), .EARLY_EXIT(1)) dut (
    .clk(clk), .clr(clr), .start(start), .ack(ack), .b_zero(b_zero),
    .ready(ready), .busy(busy), .done(done), .dp_clr(dp_clr), .dp_ld(dp_ld),
    .dp_en(dp_en), .steps(steps)
  );

  mult_ctrl #(.ITER(ITER), .CW(CW), .EARLY_EXIT(0)) dut_noexit (
    .clk(clk), .clr(clr), .start(start2), .ack(ack2), .b_zero(b_zero2),
    .ready(ready2), .busy(busy2), .done(done2), .dp_clr(dp_clr2), .dp_ld(dp_ld2),
    .dp_en(dp_en2), .steps(steps2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start, then watch edges e0.. until done; kz>0 raises b_zero so it is
  // seen at the kz-th RUN edge; poke pulses start+ack during RUN.
  task automatic run_op(input string tag, input int kz, input int exp_steps, input bit poke);
    exp_t e, x;
    int en_cnt = 0, clr_cnt = 0, ld_cnt = 0, ovl = 0;
    int clr_at = -1, ld_at = -1, done_at = -1;
    e.steps   = exp_steps;
    e.done_at = exp_steps + 2;
    exp_q.push_back(e);
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      start = 1'b0;
      ack   = 1'b0;
      if (poke && i == 4) begin
        start = 1'b1;
        ack   = 1'b1;
      end
      if (kz > 0 && (i >= kz + 1 || (kz == 1 && i >= 1))) b_zero = 1'b1;
      if (dp_clr) begin clr_cnt++; if (clr_at < 0) clr_at = i; end
      if (dp_ld)  begin ld_cnt++;  if (ld_at < 0)  ld_at  = i; end
      if (dp_en) en_cnt++;
      if (dp_en && (dp_clr || dp_ld)) ovl++;
      if (done) begin
        done_at = i;
        break;
      end
    end
    start  = 1'b0;
    ack    = 1'b0;
    b_zero = 1'b0;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      x = exp_q.pop_front();
      check({tag, "_done_at"}, done_at, x.done_at);
      check({tag, "_steps"}, steps, x.steps);
      check({tag, "_en_cnt"}, en_cnt, x.steps);
    end
    check({tag, "_clr_at"}, clr_at, 0);
    check({tag, "_ld_at"}, ld_at, 1);
    check({tag, "_clr_cnt"}, clr_cnt, 1);
    check({tag, "_ld_cnt"}, ld_cnt, 1);
    check({tag, "_overlap"}, ovl, 0);
  endtask

  task automatic do_ack(input string tag, input bit with_start);
    ack   = 1'b1;
    start = with_start;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check({tag, "_ready"}, {ready, busy, done}, 3'b100);
    tick();
    check({tag, "_idle_hold"}, {ready, dp_clr, busy}, 3'b100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, x;
    int en2, done2_at;

    // Reset held two cycles with start high: must never leave IDLE.
    clr   = 1'b1;
    start = 1'b1;
    tick();
    check("rst1_outs", {ready, busy, done, dp_clr, dp_ld, dp_en}, 6'b100000);
    tick();
    check("rst2_outs", {ready, busy, done, dp_clr, dp_ld, dp_en}, 6'b100000);
    check("rst_steps", steps, 0);
    clr   = 1'b0;
    start = 1'b0;
    tick();
    check("post_rst_idle", {ready, busy}, 2'b10);

    // Full run, then done/steps must hold while ack stays low.
    run_op("full", 0, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold%0d", i), {done, steps}, {1'b1, 4'd8});
    end
    do_ack("full_ack", 1'b0);

    run_op("early1", 1, 1, 1'b0);
    do_ack("early1_ack", 1'b0);

    run_op("early4", 4, 4, 1'b0);
    do_ack("early4_ack", 1'b0);

    // start/ack pulsed mid-run must not alter the run.
    run_op("poke", 0, 8, 1'b1);
    do_ack("ack_start", 1'b1);

    // Reset at the 5th RUN edge (e7).
    start = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      start = 1'b0;
    end
    check("mid_pre_en", dp_en, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("mid_rst_outs", {ready, busy, dp_en}, 3'b100);
    check("mid_rst_steps", steps, 0);
    tick();
    check("mid_rst_stay", {ready, dp_en}, 2'b10);
    run_op("after_rst", 0, 8, 1'b0);
    do_ack("after_rst_ack", 1'b0);

    // EARLY_EXIT=0 instance with b_zero held high.
    e.steps   = 8;
    e.done_at = 10;
    exp_q.push_back(e);
    en2      = 0;
    done2_at = -1;
    start2   = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      start2 = 1'b0;
      if (dp_en2) en2++;
      if (done2) begin
        done2_at = i;
        break;
      end
    end
    if (exp_q.size() == 0) begin
      check("noexit_queue", 0, 1);
    end else begin
      x = exp_q.pop_front();
      check("noexit_done_at", done2_at, x.done_at);
      check("noexit_steps", steps2, x.steps);
      check("noexit_en_cnt", en2, x.steps);
    end
    ack2 = 1'b1;
    tick();
    ack2 = 1'b0;
    check("noexit_ready", ready2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
